bus_arbiter_rr: RTL and testbench

Round-robin arbiter and tenure sequencer for the shared two-master / two-slave system bus. It grants one master at a time and tracks burst beats, wait states and slave responses (OKAY/ERROR/RETRY/SPLIT). It masks split masters until the slave releases them, and forces bus recovery on error or wait-state timeout. It sits ahead of the address/data mux control, which consumes grant_x and master_sel.

---
 rtl/bus_arbiter_rr_if.sv | 39 +++
 rtl/bus_arbiter_rr.sv | 159 +++++++++++++++
 tb/tb_bus_arbiter_rr.sv | 263 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/bus_arbiter_rr_if.sv
// Request/grant bundle between the two bus masters, the slave response path and
// the round-robin arbiter. The arbiter connects through the slave modport; the
// requesting side (masters, slave response, or a bench) uses the master modport.
interface bus_arbiter_rr_if #(
  parameter int unsigned LEN_W = 3
);
  logic             busreq_1;
  logic             busreq_2;
  logic             lock_1;
  logic             lock_2;
  logic [LEN_W-1:0] len_1;
  logic [LEN_W-1:0] len_2;
  logic             ready;
  logic [1:0]       response;
  logic             split_clr_1;
  logic             split_clr_2;
  logic             grant_1;
  logic             grant_2;
  logic             master_sel;
  logic             busy;
  logic             error;
  logic             timeout;
  logic             split_pend_1;
  logic             split_pend_2;

  modport master (
    output busreq_1, busreq_2, lock_1, lock_2, len_1, len_2,
    output ready, response, split_clr_1, split_clr_2,
    input  grant_1, grant_2, master_sel, busy, error, timeout,
    input  split_pend_1, split_pend_2
  );

  modport slave (
    input  busreq_1, busreq_2, lock_1, lock_2, len_1, len_2,
    input  ready, response, split_clr_1, split_clr_2,
    output grant_1, grant_2, master_sel, busy, error, timeout,
    output split_pend_1, split_pend_2
  );
endinterface

// File: rtl/bus_arbiter_rr.sv
// Round-robin arbiter and tenure sequencer for the two-master / two-slave bus.
// Grants one master at a time, counts burst beats and wait states, handles
// OKAY/ERROR/RETRY/SPLIT responses and forces a recovery cycle on error/timeout.
module bus_arbiter_rr #(
  parameter int unsigned LEN_W   = 3,
  parameter int unsigned TIMEOUT = 16,
  parameter int unsigned TO_W    = 5
) (
  input  logic            clk,
  input  logic            rst,
  bus_arbiter_rr_if.slave bus
);

  localparam logic [1:0] RespOkay  = 2'b00;
  localparam logic [1:0] RespError = 2'b01;
  localparam logic [1:0] RespRetry = 2'b10;
  localparam logic [1:0] RespSplit = 2'b11;

  typedef enum logic [1:0] {StIdle, StAddr, StData, StRecover} state_e;

  state_e            state_q;
  logic              grant_1_q, grant_2_q;
  logic              sel_q;
  logic              busy_q;
  logic              error_q, timeout_q;
  logic              split_pend_1_q, split_pend_2_q;
  logic [LEN_W-1:0]  beat_cnt_q;
  logic [TO_W-1:0]   wait_cnt_q;
  // Last granted master: 0 = master 1, 1 = master 2.
  logic              rr_q;

  logic              elig_1, elig_2, pick_1;
  logic              owner_req, owner_lock;
  logic [LEN_W-1:0]  owner_len;
  logic              wait_expired;

  // Arbitration and owner-side request decode.
  always_comb begin
    elig_1       = bus.busreq_1 & ~split_pend_1_q;
    elig_2       = bus.busreq_2 & ~split_pend_2_q;
    // On a tie the master other than the last winner goes first.
    pick_1       = elig_1 & (~elig_2 | rr_q);
    owner_req    = sel_q ? bus.busreq_2 : bus.busreq_1;
    owner_lock   = sel_q ? bus.lock_2   : bus.lock_1;
    owner_len    = sel_q ? bus.len_2    : bus.len_1;
    wait_expired = (wait_cnt_q == TO_W'(TIMEOUT - 1));
  end

  // Tenure sequencer with registered outputs.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q        <= StIdle;
      grant_1_q      <= 1'b0;
      grant_2_q      <= 1'b0;
      sel_q          <= 1'b0;
      busy_q         <= 1'b0;
      error_q        <= 1'b0;
      timeout_q      <= 1'b0;
      split_pend_1_q <= 1'b0;
      split_pend_2_q <= 1'b0;
      beat_cnt_q     <= '0;
      wait_cnt_q     <= '0;
      rr_q           <= 1'b1;
    end else begin
      error_q   <= 1'b0;
      timeout_q <= 1'b0;
      // Clears go first so a split set later in this block wins.
      if (bus.split_clr_1) split_pend_1_q <= 1'b0;
      if (bus.split_clr_2) split_pend_2_q <= 1'b0;

      unique case (state_q)
        StIdle: begin
          if (elig_1 || elig_2) begin
            grant_1_q  <= pick_1;
            grant_2_q  <= ~pick_1;
            sel_q      <= ~pick_1;
            rr_q       <= ~pick_1;
            beat_cnt_q <= pick_1 ? bus.len_1 : bus.len_2;
            busy_q     <= 1'b1;
            state_q    <= StAddr;
          end
        end

        StAddr: begin
          wait_cnt_q <= '0;
          state_q    <= StData;
        end

        StData: begin
          unique case (bus.response)
            RespError: begin
              error_q   <= 1'b1;
              grant_1_q <= 1'b0;
              grant_2_q <= 1'b0;
              state_q   <= StRecover;
            end
            RespRetry: begin
              grant_1_q <= 1'b0;
              grant_2_q <= 1'b0;
              busy_q    <= 1'b0;
              state_q   <= StIdle;
            end
            RespSplit: begin
              if (sel_q) split_pend_2_q <= 1'b1;
              else       split_pend_1_q <= 1'b1;
              grant_1_q <= 1'b0;
              grant_2_q <= 1'b0;
              busy_q    <= 1'b0;
              state_q   <= StIdle;
            end
            RespOkay: begin
              if (!bus.ready) begin
                wait_cnt_q <= wait_cnt_q + TO_W'(1);
                if (wait_expired) begin
                  timeout_q <= 1'b1;
                  grant_1_q <= 1'b0;
                  grant_2_q <= 1'b0;
                  state_q   <= StRecover;
                end
              end else if (beat_cnt_q != '0) begin
                beat_cnt_q <= beat_cnt_q - LEN_W'(1);
                wait_cnt_q <= '0;
              end else if (owner_lock && owner_req) begin
                // Locked back-to-back tenure: grant stays high.
                beat_cnt_q <= owner_len;
                state_q    <= StAddr;
              end else begin
                grant_1_q <= 1'b0;
                grant_2_q <= 1'b0;
                busy_q    <= 1'b0;
                state_q   <= StIdle;
              end
            end
            default: ;
          endcase
        end

        StRecover: begin
          grant_1_q <= 1'b0;
          grant_2_q <= 1'b0;
          busy_q    <= 1'b0;
          state_q   <= StIdle;
        end

        default: state_q <= StIdle;
      endcase
    end
  end

  assign bus.grant_1      = grant_1_q;
  assign bus.grant_2      = grant_2_q;
  assign bus.master_sel   = sel_q;
  assign bus.busy         = busy_q;
  assign bus.error        = error_q;
  assign bus.timeout      = timeout_q;
  assign bus.split_pend_1 = split_pend_1_q;
  assign bus.split_pend_2 = split_pend_2_q;

endmodule

// File: tb/tb_bus_arbiter_rr.sv
// Self-checking bench for bus_arbiter_rr: directed scenarios, a tenure-level
// reference model compared every cycle, and literal expectations per scenario.
module tb_bus_arbiter_rr;
  localparam int unsigned LEN_W   = 3;
  localparam int unsigned TIMEOUT = 16;
  localparam int unsigned TO_W    = 5;

  logic clk;
  logic rst;
  bus_arbiter_rr_if #(.LEN_W(LEN_W)) bus ();

  bus_arbiter_rr #(.LEN_W(LEN_W), .TIMEOUT(TIMEOUT), .TO_W(TO_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests;
  int n_fail;
  bit chk_en;

  // Reference model: who owns the bus, where in the tenure it is, beats left.
  // phase: 0 idle, 1 address, 2 data, 3 recovery.
  int m_phase, m_owner, m_last, m_left, m_waits, m_sel;
  bit m_sp1, m_sp2, m_err, m_to;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_step();
    int  e1, e2, win, len_o;
    bit  set1, set2, req_o, lock_o;
    if (!rst) begin
      m_phase = 0; m_owner = 0; m_last = 2; m_left = 0; m_waits = 0; m_sel = 0;
      m_sp1 = 0; m_sp2 = 0; m_err = 0; m_to = 0;
      return;
    end
    m_err = 0; m_to = 0; set1 = 0; set2 = 0;
    req_o  = (m_owner == 2) ? bus.busreq_2 : bus.busreq_1;
    lock_o = (m_owner == 2) ? bus.lock_2 : bus.lock_1;
    len_o  = (m_owner == 2) ? int'(bus.len_2) : int'(bus.len_1);
    case (m_phase)
      0: begin
        e1 = (bus.busreq_1 && !m_sp1) ? 1 : 0;
        e2 = (bus.busreq_2 && !m_sp2) ? 1 : 0;
        if (e1 == 1 && e2 == 1) win = (m_last == 1) ? 2 : 1;
        else if (e1 == 1)       win = 1;
        else if (e2 == 1)       win = 2;
        else                    win = 0;
        if (win != 0) begin
          m_owner = win; m_last = win; m_sel = win - 1; m_phase = 1;
          m_left  = ((win == 1) ? int'(bus.len_1) : int'(bus.len_2)) + 1;
        end
      end
      1: begin m_phase = 2; m_waits = 0; end
      2: begin
        case (bus.response)
          2'b01: begin m_err = 1; m_owner = 0; m_phase = 3; end
          2'b10: begin m_owner = 0; m_phase = 0; end
          2'b11: begin
            if (m_owner == 1) set1 = 1; else set2 = 1;
            m_owner = 0; m_phase = 0;
          end
          default: begin
            if (bus.ready) begin
              m_left--; m_waits = 0;
              if (m_left == 0) begin
                if (lock_o && req_o) begin m_left = len_o + 1; m_phase = 1; end
                else begin m_owner = 0; m_phase = 0; end
              end
            end else begin
              m_waits++;
              if (m_waits == int'(TIMEOUT)) begin m_to = 1; m_owner = 0; m_phase = 3; end
            end
          end
        endcase
      end
      default: begin m_owner = 0; m_phase = 0; end
    endcase
    m_sp1 = set1 | (m_sp1 & !bus.split_clr_1);
    m_sp2 = set2 | (m_sp2 & !bus.split_clr_2);
  endtask

  // Every-cycle comparison of all outputs against the model.
  always @(negedge clk) begin
    if (chk_en) begin
      chk("m_grant_1",    bus.grant_1,      (m_owner == 1) ? 1 : 0);
      chk("m_grant_2",    bus.grant_2,      (m_owner == 2) ? 1 : 0);
      chk("m_master_sel", bus.master_sel,   m_sel);
      chk("m_busy",       bus.busy,         (m_phase != 0) ? 1 : 0);
      chk("m_error",      bus.error,        m_err);
      chk("m_timeout",    bus.timeout,      m_to);
      chk("m_split_1",    bus.split_pend_1, m_sp1);
      chk("m_split_2",    bus.split_pend_2, m_sp2);
    end
  end

  task automatic tick();
    @(posedge clk);
    model_step();
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    bus.busreq_1 = 0; bus.busreq_2 = 0; bus.lock_1 = 0; bus.lock_2 = 0;
    bus.len_1 = '0; bus.len_2 = '0; bus.ready = 1; bus.response = 2'b00;
    bus.split_clr_1 = 0; bus.split_clr_2 = 0;
  endtask

  task automatic drain();
    idle_inputs();
    for (int i = 0; i < 4; i++) tick();
  endtask

  logic [1:0] alt_exp [9];
  int         cnt;
  bit         seen;

  initial begin
    n_tests = 0; n_fail = 0; chk_en = 0;
    idle_inputs();
    rst = 0;
    chk_en = 1;
    tick(); tick();
    chk("rst_grant_1", bus.grant_1, 0);
    chk("rst_busy", bus.busy, 0);
    chk("rst_sel", bus.master_sel, 0);
    chk("rst_split", {bus.split_pend_2, bus.split_pend_1}, 0);
    rst = 1;
    tick();

    // Alternating grants with both masters requesting single-beat bursts.
    alt_exp = '{2'b01, 2'b01, 2'b00, 2'b10, 2'b10, 2'b00, 2'b01, 2'b01, 2'b00};
    bus.busreq_1 = 1; bus.busreq_2 = 1;
    for (int i = 0; i < 9; i++) begin
      tick();
      chk($sformatf("alt_%0d", i), {bus.grant_2, bus.grant_1}, alt_exp[i]);
    end
    drain();

    // Master 1 alone, 4-beat burst; request dropped mid-tenure is ignored.
    bus.busreq_1 = 1; bus.len_1 = 3'd3;
    cnt = 0;
    for (int i = 0; i < 8; i++) begin
      tick();
      bus.busreq_1 = 0;
      if (bus.grant_1) cnt++;
    end
    chk("burst4_grant_cycles", cnt, 5);
    chk("burst4_busy_after", bus.busy, 0);
    drain();

    // Master 2 wait-state timeout.
    bus.busreq_2 = 1; bus.ready = 0;
    tick();
    chk("to_grant_2", bus.grant_2, 1);
    bus.busreq_2 = 0;
    cnt = 0; seen = 0;
    for (int i = 0; i < 40 && !seen; i++) begin
      tick();
      cnt++;
      if (bus.timeout) seen = 1;
    end
    chk("to_seen", seen, 1);
    chk("to_latency", cnt, 17);
    chk("to_grant_dropped", bus.grant_2, 0);
    chk("to_recover_busy", bus.busy, 1);
    bus.ready = 1;
    tick();
    chk("to_timeout_pulse", bus.timeout, 0);
    chk("to_idle_busy", bus.busy, 0);
    drain();

    // Error response from master 2's tenure.
    bus.busreq_2 = 1;
    tick(); tick();
    bus.busreq_2 = 0; bus.response = 2'b01;
    tick();
    chk("err_pulse", bus.error, 1);
    chk("err_grant_2", bus.grant_2, 0);
    bus.response = 2'b00;
    tick();
    chk("err_pulse_end", bus.error, 0);
    drain();

    // Split on master 1 (clear in the same cycle loses), then release.
    bus.busreq_1 = 1;
    tick(); tick();
    bus.response = 2'b11; bus.split_clr_1 = 1;
    tick();
    chk("split_set_wins", bus.split_pend_1, 1);
    chk("split_grant_1", bus.grant_1, 0);
    bus.response = 2'b00; bus.split_clr_1 = 0; bus.busreq_2 = 1;
    tick();
    chk("split_m2_served", bus.grant_2, 1);
    tick(); tick();
    bus.busreq_2 = 0;
    tick();
    chk("split_m1_masked", bus.grant_1, 0);
    bus.split_clr_1 = 1;
    tick();
    bus.split_clr_1 = 0;
    chk("split_cleared", bus.split_pend_1, 0);
    tick();
    chk("split_m1_granted", bus.grant_1, 1);
    drain();

    // Locked back-to-back tenure for master 1, then master 2.
    bus.busreq_1 = 1; bus.lock_1 = 1; bus.len_1 = 3'd1;
    tick();
    bus.busreq_2 = 1;
    cnt = 0;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (bus.grant_1) cnt++;
      if (i == 2) bus.lock_1 = 0;
    end
    chk("lock_no_gap", cnt, 5);
    tick();
    chk("lock_end", bus.grant_1, 0);
    tick();
    chk("lock_then_m2", bus.grant_2, 1);
    drain();

    // Reset in the middle of a 4-beat master 2 burst with master 1 split.
    bus.busreq_1 = 1;
    tick(); tick();
    bus.response = 2'b11;
    tick();
    bus.response = 2'b00; bus.busreq_1 = 0; bus.busreq_2 = 1; bus.len_2 = 3'd3;
    tick();
    chk("rstmid_sel", bus.master_sel, 1);
    tick(); tick();
    rst = 0;
    tick();
    chk("rstmid_grant", {bus.grant_2, bus.grant_1}, 0);
    chk("rstmid_busy", bus.busy, 0);
    chk("rstmid_split", bus.split_pend_1, 0);
    chk("rstmid_sel0", bus.master_sel, 0);
    rst = 1; bus.busreq_1 = 1;
    tick();
    chk("rstmid_m1_wins", bus.grant_1, 1);
    drain();

    chk_en = 0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
endmodule
